// File: rtl/vx_alu_req_arbiter.sv
// Round-robin arbiter that shares one registered ALU request port among NUM_REQS issue slots,
// with a per-source branch fence. Define ALU_ARB_PERF_EN to add stall/fence cycle counters.
module vx_alu_req_arbiter #(
  parameter int  NUM_REQS = 4,
  parameter int  DATAW    = 128,
  localparam int IDXW     = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_is_br,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_is_br,
  output logic [IDXW-1:0]           out_idx,
  input  logic                      out_ready,
  input  logic                      br_done_valid,
  input  logic [IDXW-1:0]           br_done_idx,
`ifdef ALU_ARB_PERF_EN
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_fence_cycles,
`endif
  output logic                      fence_err
);

  logic [NUM_REQS-1:0] fence_r;
  logic [NUM_REQS-1:0] fence_nxt_s;
  logic [NUM_REQS-1:0] fence_set_s;
  logic [NUM_REQS-1:0] fence_clr_s;
  logic [NUM_REQS-1:0] eligible_s;
  logic [NUM_REQS-1:0] grant_oh_s;
  logic [IDXW-1:0]     rr_ptr_r;
  logic [IDXW-1:0]     grant_idx_s;
  logic [IDXW-1:0]     cand_s;
  logic                grant_valid_s;
  logic                en_s;
  logic                fire_s;
  logic                br_idx_ok_s;
  logic                br_err_s;

  logic                out_valid_r;
  logic [DATAW-1:0]    out_data_r;
  logic                out_is_br_r;
  logic [IDXW-1:0]     out_idx_r;
  logic                fence_err_r;

  // Index arithmetic modulo NUM_REQS; also correct for non-power-of-2 source counts.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQS) begin
      sum = sum - NUM_REQS;
    end else begin
      sum = sum;
    end
    return IDXW'(sum);
  endfunction

  assign eligible_s  = req_valid & ~fence_r;
  assign en_s        = out_ready | ~out_valid_r;
  assign fire_s      = en_s & grant_valid_s;
  assign br_idx_ok_s = (int'(br_done_idx) < NUM_REQS);

  // First eligible source scanning upward from rr_ptr with wrap-around.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = {IDXW{1'b0}};
    cand_s        = {IDXW{1'b0}};
    for (int k = 0; k < NUM_REQS; k++) begin
      cand_s = wrap_add(rr_ptr_r, k);
      if (!grant_valid_s && eligible_s[cand_s]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // One-hot form of the grant, used for the handshake and the fence set.
  always_comb begin
    grant_oh_s = {NUM_REQS{1'b0}};
    if (grant_valid_s) begin
      grant_oh_s[grant_idx_s] = 1'b1;
    end else begin
      grant_oh_s = {NUM_REQS{1'b0}};
    end
  end

  assign req_ready = (reset || !en_s) ? {NUM_REQS{1'b0}} : grant_oh_s;

  // Fence set/clear resolution; a set on the same index wins over a clear.
  always_comb begin
    fence_set_s = fire_s ? (grant_oh_s & req_is_br) : {NUM_REQS{1'b0}};
    fence_clr_s = {NUM_REQS{1'b0}};
    br_err_s    = 1'b0;
    if (br_done_valid) begin
      if (!br_idx_ok_s) begin
        br_err_s = 1'b1;
      end else if (!fence_r[br_done_idx] || fence_set_s[br_done_idx]) begin
        br_err_s = 1'b1;
      end else begin
        fence_clr_s[br_done_idx] = 1'b1;
      end
    end else begin
      br_err_s = 1'b0;
    end
    fence_nxt_s = (fence_r & ~fence_clr_s) | fence_set_s;
  end

  // Control state: fences, round-robin pointer, sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fence_r     <= {NUM_REQS{1'b0}};
      rr_ptr_r    <= {IDXW{1'b0}};
      fence_err_r <= 1'b0;
    end else begin
      fence_r <= fence_nxt_s;
      if (br_err_s) begin
        fence_err_r <= 1'b1;
      end
      if (fire_s) begin
        rr_ptr_r <= wrap_add(grant_idx_s, 1);
      end
    end
  end

  // Output pipe register: loads on enable, payload holds when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATAW{1'b0}};
      out_is_br_r <= 1'b0;
      out_idx_r   <= {IDXW{1'b0}};
    end else if (en_s) begin
      out_valid_r <= grant_valid_s;
      if (grant_valid_s) begin
        out_data_r  <= req_data[grant_idx_s*DATAW +: DATAW];
        out_is_br_r <= req_is_br[grant_idx_s];
        out_idx_r   <= grant_idx_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_is_br = out_is_br_r;
  assign out_idx   = out_idx_r;
  assign fence_err = fence_err_r;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_fence_r;

  // Free-running counters of backpressure stalls and fence-blocked cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_r <= 32'd0;
      perf_fence_r <= 32'd0;
    end else begin
      if ((|eligible_s) && !en_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (|(req_valid & fence_r)) begin
        perf_fence_r <= perf_fence_r + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_fence_cycles = perf_fence_r;
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_vx_alu_req_arbiter.sv
// Scoreboard bench for vx_alu_req_arbiter: directed scenarios plus randomized traffic
// checked against a per-cycle reference model of the arbitration and fence rules.
`timescale 1ns/1ps
module tb_vx_alu_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_is_br;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_is_br;
  logic [IW-1:0]   out_idx;
  logic            out_ready;
  logic            br_done_valid;
  logic [IW-1:0]   br_done_idx;
  logic            fence_err;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          br;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t     exp_q[$];
  int       vectors = 0;
  int       miscompares = 0;

  logic [N-1:0] m_fence;
  int           m_rr;
  bit           m_out_valid;
  bit           m_fence_err;

  vx_alu_req_arbiter #(.NUM_REQS(N), .DATAW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_is_br(req_is_br), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_is_br(out_is_br), .out_idx(out_idx),
    .out_ready(out_ready),
    .br_done_valid(br_done_valid), .br_done_idx(br_done_idx),
    .fence_err(fence_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] r;
    r = '0;
    for (int w = 0; w < N*DW/32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // One cycle: drive inputs, check against the model, then advance the model across the next edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] br, input logic [N*DW-1:0] d,
                      input logic ordy, input logic bdv, input logic [IW-1:0] bdi);
    int           g;
    bit           en;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    @(posedge clk);
    #2;
    req_valid = v; req_is_br = br; req_data = d; out_ready = ordy;
    br_done_valid = bdv; br_done_idx = bdi;
    #1;
    chk("out_valid", DW'(out_valid), DW'(m_out_valid));
    chk("fence_err", DW'(fence_err), DW'(m_fence_err));
    en = ordy || !m_out_valid;
    g = -1;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (g < 0 && v[i] && !m_fence[i]) g = i;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    if (bdv) begin
      if (int'(bdi) >= N || !m_fence[bdi]) m_fence_err = 1'b1;
      else m_fence[bdi] = 1'b0;
    end
    if (g >= 0) begin
      e.d = d[g*DW +: DW]; e.br = br[g]; e.idx = IW'(g);
      exp_q.push_back(e);
      m_rr = (g + 1) % N;
      if (br[g]) m_fence[g] = 1'b1;
    end
    if (en) m_out_valid = (g >= 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1; req_valid = '1; req_is_br = '0; br_done_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_is_br", DW'(out_is_br), '0);
    chk("rst_out_idx", DW'(out_idx), '0);
    chk("rst_fence_err", DW'(fence_err), '0);
    chk("rst_req_ready", DW'(req_ready), '0);
    @(posedge clk);
    #2;
    req_valid = '0;
    reset = 1'b0;
    m_fence = '0; m_rr = 0; m_out_valid = 1'b0; m_fence_err = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks held outputs under backpressure.
  initial begin
    bit            hold;
    logic [DW-1:0] hd;
    logic          hb;
    logic [IW-1:0] hi;
    exp_t          e;
    hold = 1'b0; hd = '0; hb = 1'b0; hi = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", DW'(out_valid), DW'(1));
          chk("hold_data", out_data, hd);
          chk("hold_is_br", DW'(out_is_br), DW'(hb));
          chk("hold_idx", DW'(out_idx), DW'(hi));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_output: got idx %0d expected no output at %0t", out_idx, $time);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_is_br", DW'(out_is_br), DW'(e.br));
            chk("out_idx", DW'(out_idx), DW'(e.idx));
          end
        end
        hold = out_valid && !out_ready;
        hd = out_data; hb = out_is_br; hi = out_idx;
      end
    end
  end

  initial begin
    logic [N*DW-1:0] d;
    logic [N-1:0]    v;
    logic [N-1:0]    br;
    reset = 1'b1; req_valid = '1; req_is_br = '0; req_data = '0; out_ready = 1'b0;
    br_done_valid = 1'b0; br_done_idx = '0;
    m_fence = '0; m_rr = 0; m_out_valid = 1'b0; m_fence_err = 1'b0;
    do_reset();

    // all sources valid, continuous out_ready: 0,1,2,3,0,1,...
    for (int c = 0; c < 8; c++) step(4'b1111, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);

    // branch fence on source 2, released by br_done five cycles after the grant
    step(4'b0100, 4'b0100, rnd_data(), 1'b1, 1'b0, 2'd0);
    for (int c = 0; c < 5; c++) step(4'b0100, 4'b0100, rnd_data(), 1'b1, (c == 4), 2'd2);
    for (int c = 0; c < 2; c++) step(4'b0100, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);

    // backpressure holding 0xA5 from source 1
    d = '0;
    d[1*DW +: DW] = 128'hA5;
    step(4'b0010, 4'b0000, d, 1'b1, 1'b0, 2'd0);
    for (int c = 0; c < 3; c++) step(4'b1111, 4'b0000, rnd_data(), 1'b0, 1'b0, 2'd0);
    step(4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);

    // rr_ptr=1 with sources 0 and 3: 3,0,3
    step(4'b0001, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);
    for (int c = 0; c < 3; c++) step(4'b1001, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);

    // br_done for an unfenced source raises the sticky error
    step(4'b1111, 4'b0000, rnd_data(), 1'b1, 1'b1, 2'd1);
    for (int c = 0; c < 3; c++) step(4'b1111, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);

    // reset while the output is valid and source 0 is fenced
    step(4'b0001, 4'b0001, rnd_data(), 1'b1, 1'b0, 2'd0);
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0, 2'd0);
    do_reset();
    step(4'b0001, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);
    step(4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);

    // randomized traffic with occasional mid-run resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        v  = 4'($urandom);
        br = 4'($urandom) & 4'($urandom);
        step(v, br, rnd_data(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
             2'($urandom_range(0, N - 1)));
      end
    end

    for (int c = 0; c < 4; c++) step(4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    chk("queue_drained", DW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vx_alu_req_arbiter.md
Name: vx_alu_req_arbiter

Overview:
- Shares one ALU request port among NUM_REQS issue sources (per-warp issue slots).
- Uses round-robin arbitration into a single registered output stage that feeds the ALU unit request interface.
- Enforces a per-source branch fence. After a source's branch op is accepted, that source gets no further grants until the ALU reports that the branch is resolved for that source.

Parameters:
- NUM_REQS, 4, number of requesting sources (>=2).
- DATAW, 128, opaque request payload width (uuid/wid/tmask/PC/operands packed by the issuer).
- IDXW, $clog2(NUM_REQS), source index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQS  per-source request valid.
- req_data  in  NUM_REQS*DATAW  per-source payload; source i occupies bits [i*DATAW +: DATAW].
- req_is_br  in  NUM_REQS  per-source flag marking the request as a branch/jump op.
- req_ready  out  NUM_REQS  per-source accept; a transfer is req_valid[i] && req_ready[i].
- out_valid  out  1  request valid to the ALU.
- out_data  out  DATAW  granted payload.
- out_is_br  out  1  granted request is a branch.
- out_idx  out  IDXW  source index of the granted request.
- out_ready  in  1  ALU can accept.
- br_done_valid  in  1  branch resolved (driven from the branch control valid).
- br_done_idx  in  IDXW  source whose branch resolved.
- fence_err  out  1  sticky flag: br_done arrived for a source with no fence set.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_is_br=0, out_idx=0, fence[]=0, rr_ptr=0, fence_err=0. req_ready=0 while reset is asserted.
- Eligibility: eligible[i] = req_valid[i] && !fence[i].
- Stage enable: en = out_ready || !out_valid (pipe-register rule). When en=0, all req_ready are 0 and the output holds stable.
- Grant selection: when en=1, grant the first eligible index found scanning from rr_ptr upward with wrap-around, mod NUM_REQS.
  - req_ready[g]=1 for the granted index only. At most one req_ready is high per cycle.
  - If no source is eligible, no grant is made.
- Output register on the en edge:
  - With a grant g: out_valid<=1, out_data<=req_data[g], out_is_br<=req_is_br[g], out_idx<=g, rr_ptr<=(g+1) mod NUM_REQS.
  - Without a grant: out_valid<=0; out_data, out_is_br and out_idx hold; rr_ptr holds.
- Latency: one cycle from req transfer to out_valid. Full throughput is one request per cycle while out_ready=1.
- Fence set: fence[g]<=1 when a grant occurs with req_is_br[g]=1. The fence is set at the accept edge, so that source is ineligible from the next cycle.
- Fence clear: fence[br_done_idx]<=0 when br_done_valid=1.
  - A set and a clear on the same index in the same cycle cannot legally occur, because a fenced source is never granted.
  - If it occurs anyway, set wins and fence_err<=1.
- br_done_valid for an index whose fence is already 0: no state change except fence_err<=1. fence_err clears only on reset.
- br_done_idx >= NUM_REQS (non-power-of-2 configurations): ignored; fence_err<=1.
- Fairness: a source that stays continuously eligible is granted within NUM_REQS grants.
- Backpressure: held output data and flags are stable while out_valid && !out_ready.
  - A requester may drop req_valid without a transfer; the arbiter takes no action and has no obligation.
- Reset mid-operation: all fences and the in-flight output are discarded. Any later br_done for them is flagged as fence_err and otherwise ignored.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined: adds outputs perf_stall_cycles (32, cycles with any eligible request but en=0) and perf_fence_cycles (32, cycles where some req_valid[i] is blocked only by fence[i]).
  - Both are free-running, wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; the behaviour above is otherwise identical.

Test Plan:
- All 4 sources valid, non-branch, out_ready=1 constantly, rr_ptr=0 -> out_idx sequence 0,1,2,3,0,1, with out_valid high every cycle from cycle 1.
- Source 2 alone valid with req_is_br=1; br_done (idx=2) is pulsed 5 cycles after the grant -> source 2 granted once. req_ready[2]=0 until the cycle after br_done, then granted again.
- out_ready=0 for 3 cycles with output holding data 0xA5 from source 1 -> out_data/out_idx stable at 0xA5/1, all req_ready=0, and no rr_ptr advance.
- Sources 0 and 3 valid, rr_ptr=1 -> 3 granted first, then 0, then 3.
- br_done_valid with idx=1 while fence[1]=0 -> fence_err rises next cycle and stays high; all grants are unaffected.
- Assert reset while out_valid=1 and fence[0]=1 -> out_valid=0 and fence cleared immediately (async). Next cycle after release, source 0 is eligible and granted.
